// File: rtl/apb_master_bridge_pkg.sv
// Shared types and widths for the APB master bridge.
// The optional transfer timeout is enabled with APB_BRIDGE_TIMEOUT_EN.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_SW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Reads never carry byte strobes onto the bus.
    function automatic logic [APB_SW-1:0] strobe_mask(input logic we, input logic [APB_SW-1:0] strb);
        return we ? strb : '0;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response port and APB bus of the bridge in one bundle.
// The bridge itself does not depend on APB_BRIDGE_TIMEOUT_EN here.
interface apb_master_bridge_if #(
    parameter int a_w = 8
);
    import apb_pkg::*;

    // A request transfers on a cycle where req_valid and req_ready are both high;
    // until then the requester holds req_valid and all req_* fields stable.
    // resp_valid is a single-cycle pulse with no backpressure.
    logic              req_valid;
    logic              req_ready;
    logic [a_w-1:0]    req_addr;
    logic [APB_DW-1:0] req_wdata;
    logic [APB_SW-1:0] req_strb;
    logic              req_we;
    logic              resp_valid;
    logic [APB_DW-1:0] resp_rdata;
    logic              resp_err;
    logic [a_w-1:0]    paddr;
    logic [APB_DW-1:0] pwdata;
    logic [APB_SW-1:0] pstrb;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_addr, req_wdata, req_strb, req_we, prdata, pready, pslverr,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output paddr, pwdata, pstrb, pwrite, psel, penable
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_strb, req_we, prdata, pready, pslverr,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  paddr, pwdata, pstrb, pwrite, psel, penable
    );

endinterface

// File: rtl/apb_master_bridge_timeout_cnt.sv
// ACCESS wait-cycle counter; only instantiated when APB_BRIDGE_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
    parameter int to_c = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    localparam logic [15:0] LIMIT = 16'(to_c);

    logic [15:0] cnt;

    assign hit = (cnt == LIMIT);

    // Stops at the limit so a held stall can never wrap back below it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !hit) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB3/APB4 master, one transfer in flight.
// Define APB_BRIDGE_TIMEOUT_EN to abort ACCESS phases stalled for to_c cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int a_w  = 8,
    parameter int to_c = 255
) (
    input  logic                pclk,
    input  logic                preset,
    apb_master_bridge_if.master bus,
    output apb_state_t          state
);
    logic [a_w-1:0]    paddr_q;
    logic [APB_DW-1:0] pwdata_q;
    logic [APB_SW-1:0] pstrb_q;
    logic              pwrite_q;
    logic              resp_valid_q;
    logic [APB_DW-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic              timeout_hit;

    if (to_c < 1 || to_c > 65535) begin : g_bad_to_c
        $error("apb_master_bridge: to_c must be in 1..65535");
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    apb_timeout_cnt #(
        .to_c(to_c)
    ) u_timeout (
        .clk (pclk),
        .rst (preset),
        .clr (state == SETUP),
        .inc (state == ACCESS && !bus.pready),
        .hit (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state        <= IDLE;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            pwrite_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        paddr_q  <= bus.req_addr;
                        pwdata_q <= bus.req_wdata;
                        pstrb_q  <= strobe_mask(bus.req_we, bus.req_strb);
                        pwrite_q <= bus.req_we;
                        state    <= SETUP;
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    // A ready slave wins over a timeout reached in the same cycle.
                    if (bus.pready) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= bus.pslverr;
                        resp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        state        <= IDLE;
                    end else if (timeout_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.psel       = (state != IDLE);
    assign bus.penable    = (state == ACCESS);
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pstrb      = pstrb_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; covers both APB_BRIDGE_TIMEOUT_EN builds.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic pclk = 1'b0;
  logic preset;
  apb_state_t state;
  int n_tests = 0;
  int n_fail = 0;

  apb_master_bridge_if #(.a_w(8)) bus ();

  apb_master_bridge #(.a_w(8), .to_c(4)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.master),
    .state  (state)
  );

  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_we    = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
  endtask

  task automatic drive_req(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic we);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_strb  = s;
    bus.req_we    = we;
  endtask

  task automatic test_reset();
    idle_inputs();
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;
    n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state, IDLE); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_tests++; if ({bus.psel, bus.penable} !== 2'b00) begin n_fail++; $display("FAIL rst_psel_penable: got %b want 00", {bus.psel, bus.penable}); end
    n_tests++; if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 34'h0) begin n_fail++; $display("FAIL rst_resp: got %h want 0", {bus.resp_valid, bus.resp_err, bus.resp_rdata}); end
    n_tests++; if ({bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite} !== 45'h0) begin n_fail++; $display("FAIL rst_pbus: got %h want 0", {bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite}); end
    tick();
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write();
    drive_req(8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    bus.pready = 1'b1;
    tick();
    n_tests++; if (state !== SETUP) begin n_fail++; $display("FAIL wr_c1_state: got %0d want %0d", state, SETUP); end
    n_tests++; if ({bus.psel, bus.penable, bus.req_ready} !== 3'b100) begin n_fail++; $display("FAIL wr_c1_ctrl: got %b want 100", {bus.psel, bus.penable, bus.req_ready}); end
    n_tests++; if (bus.paddr !== 8'h10) begin n_fail++; $display("FAIL wr_paddr: got %h want 10", bus.paddr); end
    n_tests++; if (bus.pwdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_pwdata: got %h want deadbeef", bus.pwdata); end
    n_tests++; if ({bus.pstrb, bus.pwrite} !== 5'b11111) begin n_fail++; $display("FAIL wr_pstrb_pwrite: got %b want 11111", {bus.pstrb, bus.pwrite}); end
    bus.req_valid = 1'b0;
    tick();
    n_tests++; if ({state == ACCESS, bus.psel, bus.penable, bus.resp_valid} !== 4'b1110) begin n_fail++; $display("FAIL wr_c2_access: got %b want 1110", {state == ACCESS, bus.psel, bus.penable, bus.resp_valid}); end
    tick();
    n_tests++; if ({bus.resp_valid, bus.resp_err} !== 2'b10) begin n_fail++; $display("FAIL wr_c3_resp: got %b want 10", {bus.resp_valid, bus.resp_err}); end
    n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_c3_rdata: got %h want 0", bus.resp_rdata); end
    n_tests++; if ({bus.req_ready, bus.psel, bus.penable} !== 3'b100) begin n_fail++; $display("FAIL wr_c3_ctrl: got %b want 100", {bus.req_ready, bus.psel, bus.penable}); end
    tick();
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_c4_pulse: got %b want 0", bus.resp_valid); end
    n_tests++; if (bus.paddr !== 8'h10) begin n_fail++; $display("FAIL wr_c4_paddr_hold: got %h want 10", bus.paddr); end
    bus.pready = 1'b0;
  endtask

  task automatic test_read_wait();
    drive_req(8'h24, 32'hAAAA5555, 4'hF, 1'b0);
    bus.prdata = 32'h12345678;
    bus.pready = 1'b0;
    tick();
    n_tests++; if ({bus.pstrb, bus.pwrite} !== 5'b00000) begin n_fail++; $display("FAIL rd_pstrb_pwrite: got %b want 00000", {bus.pstrb, bus.pwrite}); end
    n_tests++; if (bus.paddr !== 8'h24) begin n_fail++; $display("FAIL rd_paddr_c1: got %h want 24", bus.paddr); end
    bus.req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      n_tests++; if ({state == ACCESS, bus.penable, bus.resp_valid} !== 3'b110) begin n_fail++; $display("FAIL rd_wait_c%0d: got %b want 110", c, {state == ACCESS, bus.penable, bus.resp_valid}); end
      n_tests++; if (bus.paddr !== 8'h24) begin n_fail++; $display("FAIL rd_paddr_c%0d: got %h want 24", c, bus.paddr); end
    end
    bus.pready = 1'b1;
    tick();
    n_tests++; if ({bus.resp_valid, bus.resp_err} !== 2'b10) begin n_fail++; $display("FAIL rd_c6_resp: got %b want 10", {bus.resp_valid, bus.resp_err}); end
    n_tests++; if (bus.resp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_c6_rdata: got %h want 12345678", bus.resp_rdata); end
    bus.pready = 1'b0;
    bus.prdata = '0;
    tick();
    n_tests++; if ({bus.resp_valid, bus.resp_rdata} !== 33'h012345678) begin n_fail++; $display("FAIL rd_c7_hold: got %h want 012345678", {bus.resp_valid, bus.resp_rdata}); end
  endtask

  task automatic test_slverr();
    drive_req(8'h30, 32'h0, 4'hF, 1'b0);
    bus.prdata  = 32'hCAFE0001;
    bus.pslverr = 1'b1;
    bus.pready  = 1'b1;
    tick();
    drive_req(8'h40, 32'h0BADF00D, 4'h3, 1'b1);
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL err_c1_ready: got %b want 0", bus.req_ready); end
    tick();
    tick();
    n_tests++; if ({bus.resp_valid, bus.resp_err, bus.req_ready} !== 3'b111) begin n_fail++; $display("FAIL err_c3_resp: got %b want 111", {bus.resp_valid, bus.resp_err, bus.req_ready}); end
    n_tests++; if (bus.resp_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL err_c3_rdata: got %h want cafe0001", bus.resp_rdata); end
    tick();
    n_tests++; if (state !== SETUP) begin n_fail++; $display("FAIL err_c4_accept: got %0d want %0d", state, SETUP); end
    n_tests++; if ({bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite} !== {8'h40, 32'h0BADF00D, 4'h3, 1'b1}) begin n_fail++; $display("FAIL err_c4_pbus: got %h want %h", {bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite}, {8'h40, 32'h0BADF00D, 4'h3, 1'b1}); end
    bus.req_valid = 1'b0;
    bus.pslverr   = 1'b0;
    tick();
    tick();
    n_tests++; if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 34'h2_0000_0000) begin n_fail++; $display("FAIL err_c6_wr_resp: got %h want 200000000", {bus.resp_valid, bus.resp_err, bus.resp_rdata}); end
    bus.pready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_psel [6];
    int resp_cnt;
    exp_psel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    resp_cnt = 0;
    drive_req(8'h50, 32'h11111111, 4'hF, 1'b1);
    bus.pready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_tests++; if (bus.psel !== exp_psel[c-1]) begin n_fail++; $display("FAIL b2b_psel_c%0d: got %b want %b", c, bus.psel, exp_psel[c-1]); end
      if (bus.resp_valid === 1'b1) resp_cnt++;
      if (c == 1) drive_req(8'h54, 32'h22222222, 4'hF, 1'b1);
      if (c == 4) bus.req_valid = 1'b0;
    end
    n_tests++; if (resp_cnt != 2) begin n_fail++; $display("FAIL b2b_resp_count: got %0d want 2", resp_cnt); end
    n_tests++; if ({bus.paddr, bus.pwdata} !== {8'h54, 32'h22222222}) begin n_fail++; $display("FAIL b2b_second_pbus: got %h want 5422222222", {bus.paddr, bus.pwdata}); end
    bus.pready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_req(8'h60, 32'h0, 4'hF, 1'b0);
    bus.pready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    n_tests++; if (state !== ACCESS) begin n_fail++; $display("FAIL rstm_c2_state: got %0d want %0d", state, ACCESS); end
    preset = 1'b1;
    tick();
    n_tests++; if ({state == IDLE, bus.psel, bus.penable, bus.resp_valid} !== 4'b1000) begin n_fail++; $display("FAIL rstm_c3: got %b want 1000", {state == IDLE, bus.psel, bus.penable, bus.resp_valid}); end
    preset = 1'b0;
    bus.pready = 1'b1;
    tick();
    n_tests++; if ({state == IDLE, bus.resp_valid} !== 2'b10) begin n_fail++; $display("FAIL rstm_c4: got %b want 10", {state == IDLE, bus.resp_valid}); end
    bus.pready = 1'b0;
  endtask

  task automatic test_timeout();
    drive_req(8'h70, 32'h0, 4'hF, 1'b0);
    bus.prdata = 32'hFFFF0000;
    bus.pready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
    for (int c = 2; c <= 6; c++) begin
      tick();
      n_tests++; if ({state == ACCESS, bus.resp_valid} !== 2'b10) begin n_fail++; $display("FAIL to_wait_c%0d: got %b want 10", c, {state == ACCESS, bus.resp_valid}); end
    end
    tick();
    n_tests++; if ({bus.resp_valid, bus.resp_err, bus.psel, bus.penable} !== 4'b1100) begin n_fail++; $display("FAIL to_c7_resp: got %b want 1100", {bus.resp_valid, bus.resp_err, bus.psel, bus.penable}); end
    n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_c7_rdata: got %h want 0", bus.resp_rdata); end
    tick();
`else
    begin
      int pulses;
      pulses = 0;
      repeat (100) begin
        tick();
        if (bus.resp_valid === 1'b1) pulses++;
      end
      n_tests++; if ({state == ACCESS, bus.psel, bus.penable} !== 3'b111) begin n_fail++; $display("FAIL nto_still_access: got %b want 111", {state == ACCESS, bus.psel, bus.penable}); end
      n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL nto_no_resp: got %0d want 0", pulses); end
      preset = 1'b1;
      tick();
      preset = 1'b0;
    end
`endif
    bus.prdata = '0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Converts a simple valid/ready request port into APB3/APB4 transfers. It issues SETUP and ACCESS phases toward `apb_mux`, and returns one response per request. It sits between the CPU-side bus and `apb_mux`: it drives `paddr`/`psel` into the mux and consumes the mux's `prdata`/`pready`. It handles one transfer at a time and can optionally abort stalled transfers with a timeout.

## Interface
Parameters:
- `a_w`, 8, address width; matches `apb_mux` `a_w`.
- `to_c`, 255, timeout limit in ACCESS wait cycles. Used only when `APB_BRIDGE_TIMEOUT_EN` is defined. Legal range 1..65535.

Ports:
- `pclk`  in  1  clock.
- `preset`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_addr`  in  `a_w`  request address.
- `req_wdata`  in  32  write data.
- `req_strb`  in  4  write byte strobes.
- `req_we`  in  1  1 = write, 0 = read.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  32  read data. Value is 0 for writes and for timed-out transfers.
- `resp_err`  out  1  `pslverr` from the slave, or timeout.
- `paddr`  out  `a_w`  APB address.
- `pwdata`  out  32  APB write data.
- `pstrb`  out  4  APB strobes. Forced to 0 on reads.
- `pwrite`  out  1  APB direction.
- `psel`  out  1  APB select, toward `apb_mux`.
- `penable`  out  1  APB enable.
- `prdata`  in  32  APB read data, from `apb_mux`.
- `pready`  in  1  APB ready, from `apb_mux`.
- `pslverr`  in  1  APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - `req_ready`=1; `psel`=0, `penable`=0.
  - On `req_valid & req_ready`: register `req_addr`, `req_wdata`, `req_strb` (0 if read) and `req_we` into the `p*` output registers, then go to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0, `req_ready`=0.
  - Always goes to ACCESS on the next cycle.
- **ACCESS**
  - `psel`=1, `penable`=1, `req_ready`=0.
  - If `pready`=0: stay in ACCESS.
  - If `pready`=1: go to IDLE and register the response. `resp_valid`=1, `resp_err`=`pslverr`. `resp_rdata`=`prdata` if read, else 0.
- `paddr`, `pwdata`, `pstrb` and `pwrite` hold from SETUP until the end of ACCESS. In IDLE they keep their last value; they never toggle while `psel`=1.
- `resp_valid` is high for exactly one cycle. `resp_rdata` and `resp_err` hold until the next response.
- A request arriving in SETUP or ACCESS is not accepted (`req_ready`=0). The requester must hold it stable until accepted.
- An unmapped address needs no special handling: `apb_mux` returns `pready`=1 and `prdata`=0, so the transfer completes after one ACCESS cycle with `resp_rdata`=0.
- Reset values: state IDLE; all `p*` outputs, `resp_*` and the timeout counter are 0; `req_ready`=1 in the first cycle after `preset` deasserts.
- Reset mid-transfer: on the next edge the FSM returns to IDLE with `psel`=`penable`=0, and no `resp_valid` is produced.

## Timing
- Request accepted at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With `pready`=1 in cycle 2, `resp_valid` and `req_ready` are both high in cycle 3.
- Minimum latency from accept to response is 3 cycles. Each `pready`=0 cycle in ACCESS adds one cycle.
- Back-to-back: a request accepted in cycle 3 reaches SETUP in cycle 4. Maximum throughput is one transfer per 3 cycles.
- `req_ready`, `psel` and `penable` are decoded only from the state register. No input-to-output combinational path exists.

## Configuration
- Macro: `APB_BRIDGE_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entering ACCESS and increments each ACCESS cycle with `pready`=0.
  - When the count equals `to_c` and `pready` is still 0, the bridge ends the transfer. On the next edge: go to IDLE, `psel`=`penable`=0, `resp_valid`=1, `resp_err`=1, `resp_rdata`=0.
  - If `pready`=1 in the same cycle the limit is reached, the normal completion takes priority.
- **Undefined:** no counter is built; the bridge waits indefinitely and `to_c` is ignored.

## Structure
- Package `apb_pkg` holds:
  - the state enum `apb_state_t` (IDLE, SETUP, ACCESS);
  - `APB_DW` = 32;
  - `APB_SW` = 4.
- The timeout counter is a sub-module `apb_timeout_cnt`, instantiated only under `APB_BRIDGE_TIMEOUT_EN`:
  - inputs: `clr`, `inc`;
  - output: `hit`;
  - parameter: `to_c`.

## Test plan
- Write: addr 0x10, data 0xDEADBEEF, strb 0xF, `pready` tied 1 → SETUP cycle 1, ACCESS cycle 2; `resp_valid` in cycle 3 with `resp_err`=0 and `resp_rdata`=0.
- Read: addr 0x24, slave drives `prdata`=0x12345678 and holds `pready`=0 for 3 ACCESS cycles → `resp_rdata`=0x12345678 six cycles after accept; `paddr` stable throughout.
- `pslverr`=1 on a read → `resp_err`=1, `resp_rdata` = the `prdata` value; next request accepted in the same cycle as `resp_valid`.
- Two back-to-back requests with `req_valid` held high → second accepted in cycle 3; `psel` low for exactly one cycle between the transfers.
- `preset` asserted during ACCESS → `psel`=`penable`=0 next cycle; no `resp_valid`.
- With `APB_BRIDGE_TIMEOUT_EN` and `to_c`=4, `pready` held 0 → `resp_valid`=1, `resp_err`=1, `resp_rdata`=0 after 4 wait cycles. Without the macro, the bridge is still in ACCESS after 100 cycles.
